// File: rtl/ct_ifu_icache_pkg.sv
// Shared definitions for the IFU I-cache refill write path: FSM encoding,
// line geometry and the beat-field position inside the array index.
package ct_ifu_icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } refill_state_e;

    localparam int REFILL_BEATS = 4;
    localparam int REFILL_BANKS = 4;
    localparam int BEAT_CNT_W   = $clog2(REFILL_BEATS);
    // A line occupies index[4:0]: beat number in [4:3], row offset [2:0] always zero.
    localparam int BEAT_LSB     = 3;
    localparam int LINE_OFF_W   = 5;

endpackage

// File: rtl/ct_ifu_icache_refill_wr_if.sv
// Refill-buffer side handshake plus the data-array write bus of the refill writer.
interface ct_ifu_icache_refill_wr_if
    import ct_ifu_icache_pkg::*;
#(
    parameter int IDX_W  = 16,
    parameter int DATA_W = 128
);
    logic                        refill_req_vld;
    logic [IDX_W-LINE_OFF_W-1:0] refill_req_idx;
    logic                        refill_req_way;
    logic                        refill_req_rdy;
    logic                        refill_data_vld;
    logic [DATA_W-1:0]           refill_data;
    logic                        refill_data_rdy;
    logic                        ifu_rd_hold;
    logic                        refill_abort;
    logic                        refill_done;
    logic [IDX_W-1:0]            icache_wr_index;
    logic [DATA_W-1:0]           icache_wr_din;
    logic                        icache_wr_array0_cen_b;
    logic                        icache_wr_array1_cen_b;
    logic [REFILL_BANKS-1:0]     icache_wr_array0_clk_en;
    logic [REFILL_BANKS-1:0]     icache_wr_array1_clk_en;
    logic                        icache_wr_wen_b;

    modport slave (
        input  refill_req_vld, refill_req_idx, refill_req_way,
        input  refill_data_vld, refill_data, ifu_rd_hold, refill_abort,
        output refill_req_rdy, refill_data_rdy, refill_done,
        output icache_wr_index, icache_wr_din, icache_wr_wen_b,
        output icache_wr_array0_cen_b, icache_wr_array1_cen_b,
        output icache_wr_array0_clk_en, icache_wr_array1_clk_en
    );

    modport master (
        output refill_req_vld, refill_req_idx, refill_req_way,
        output refill_data_vld, refill_data, ifu_rd_hold, refill_abort,
        input  refill_req_rdy, refill_data_rdy, refill_done,
        input  icache_wr_index, icache_wr_din, icache_wr_wen_b,
        input  icache_wr_array0_cen_b, icache_wr_array1_cen_b,
        input  icache_wr_array0_clk_en, icache_wr_array1_clk_en
    );

endinterface

// File: rtl/ct_ifu_icache_refill_wr_drv.sv
// Registered array write stage: one accepted beat becomes a single-cycle
// write strobe on the selected data array; index/din hold between writes.
module ct_ifu_icache_refill_wr_drv
    import ct_ifu_icache_pkg::*;
#(
    parameter int IDX_W  = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = BEAT_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        way,
    input  logic [IDX_W-LINE_OFF_W-1:0] idx,
    input  logic [CNT_W-1:0]            cnt,
    input  logic [DATA_W-1:0]           beat,
    output logic [IDX_W-1:0]            index,
    output logic [DATA_W-1:0]           din,
    output logic                        array0_cen_b,
    output logic                        array1_cen_b,
    output logic [REFILL_BANKS-1:0]     array0_clk_en,
    output logic [REFILL_BANKS-1:0]     array1_clk_en,
    output logic                        wen_b
);

    logic wr0_s;
    logic wr1_s;

    assign wr0_s = wr_en & ~way;
    assign wr1_s = wr_en &  way;

    // Strobes follow the accept every cycle; address/data only load on a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index         <= {IDX_W{1'b0}};
            din           <= {DATA_W{1'b0}};
            array0_cen_b  <= 1'b1;
            array1_cen_b  <= 1'b1;
            array0_clk_en <= {REFILL_BANKS{1'b0}};
            array1_clk_en <= {REFILL_BANKS{1'b0}};
            wen_b         <= 1'b1;
        end else begin
            array0_cen_b  <= ~wr0_s;
            array1_cen_b  <= ~wr1_s;
            array0_clk_en <= {REFILL_BANKS{wr0_s}};
            array1_clk_en <= {REFILL_BANKS{wr1_s}};
            wen_b         <= ~wr_en;
            if (wr_en) begin
                index <= {idx, cnt, {BEAT_LSB{1'b0}}};
                din   <= beat;
            end else begin
                index <= index;
                din   <= din;
            end
        end
    end

endmodule

// File: rtl/ct_ifu_icache_refill_wr.sv
// I-cache line refill writer: accepts a line request, then four beats, each
// written to the chosen data array one cycle after acceptance. Fetch reads win.
module ct_ifu_icache_refill_wr
    import ct_ifu_icache_pkg::*;
#(
    parameter int IDX_W  = 16,
    parameter int DATA_W = 128,
    parameter int BEATS  = REFILL_BEATS
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    ct_ifu_icache_refill_wr_if.slave  bus
);

    localparam int CNT_W = $clog2(BEATS);

    refill_state_e               state_r;
    refill_state_e               next_state_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [IDX_W-LINE_OFF_W-1:0] idx_r;
    logic                        way_r;
    logic                        req_rdy_r;
    logic                        done_r;
    logic                        req_acc_s;
    logic                        beat_acc_s;
    logic                        data_rdy_s;
    logic                        abort_s;
    logic                        last_beat_s;

    // Next-state and handshake decode; abort only matters while filling.
    always_comb begin
        next_state_s = state_r;
        req_acc_s    = 1'b0;
        data_rdy_s   = 1'b0;
        beat_acc_s   = 1'b0;
        abort_s      = 1'b0;
        last_beat_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_acc_s = bus.refill_req_vld & req_rdy_r;
                if (req_acc_s) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                abort_s     = bus.refill_abort;
                data_rdy_s  = ~bus.ifu_rd_hold & ~bus.refill_abort;
                beat_acc_s  = data_rdy_s & bus.refill_data_vld;
                last_beat_s = beat_acc_s & (cnt_r == CNT_W'(BEATS - 1));
                if (abort_s) begin
                    next_state_s = ST_IDLE;
                end else if (last_beat_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered request-ready and done pulse.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_r   <= ST_IDLE;
            req_rdy_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            req_rdy_r <= (next_state_s == ST_IDLE);
            done_r    <= last_beat_s;
        end
    end

    // Line context and beat counter; the counter only restarts via a new request or abort.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {(IDX_W-LINE_OFF_W){1'b0}};
            way_r <= 1'b0;
        end else if (req_acc_s) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= bus.refill_req_idx;
            way_r <= bus.refill_req_way;
        end else if (abort_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (beat_acc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.refill_req_rdy  = req_rdy_r;
    assign bus.refill_data_rdy = data_rdy_s;
    assign bus.refill_done     = done_r;

    ct_ifu_icache_refill_wr_drv #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_drv (
        .clk           (forever_cpuclk),
        .rst           (cpurst),
        .wr_en         (beat_acc_s),
        .way           (way_r),
        .idx           (idx_r),
        .cnt           (cnt_r),
        .beat          (bus.refill_data),
        .index         (bus.icache_wr_index),
        .din           (bus.icache_wr_din),
        .array0_cen_b  (bus.icache_wr_array0_cen_b),
        .array1_cen_b  (bus.icache_wr_array1_cen_b),
        .array0_clk_en (bus.icache_wr_array0_clk_en),
        .array1_clk_en (bus.icache_wr_array1_clk_en),
        .wen_b         (bus.icache_wr_wen_b)
    );

endmodule
